vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator and output stage. Successor to the fixed-porch sync block.
- Owns its own column and row counters. It publishes the current pixel coordinate to an upstream pixel source, then receives that source's colour after a configurable latency.
- Emits HSync, VSync, active flag and blanked RGB, all mutually aligned, plus line-start and frame-start strobes.
- Sits between the pattern/frame-buffer logic and the VGA pins.

Parameters:
- VIDEO_WIDTH, 3, bits per colour channel.
- ACTIVE_COLS, 640, visible pixels per line.
- H_FRONT, 18, horizontal front porch in clocks.
- H_SYNC, 92, HSync pulse width in clocks.
- H_BACK, 50, horizontal back porch in clocks.
- ACTIVE_ROWS, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, VSync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high).
- VIDEO_DELAY, 2, latency in clocks from o_Col/o_Row to the matching i_*_Video. Legal range 0..8.
- COUNT_WIDTH, 10, width of the coordinate counters. Must hold TOTAL_COLS-1 and TOTAL_ROWS-1.

Ports:
- i_Clk, in, 1, pixel clock (25 MHz for 640x480).
- i_Reset, in, 1, synchronous reset, active-high.
- i_Red_Video, in, VIDEO_WIDTH, source red for the pixel published VIDEO_DELAY clocks earlier.
- i_Grn_Video, in, VIDEO_WIDTH, source green, same timing as red.
- i_Blu_Video, in, VIDEO_WIDTH, source blue, same timing as red.
- o_Col, out, COUNT_WIDTH, current column counter (registered).
- o_Row, out, COUNT_WIDTH, current row counter (registered).
- o_HSync, out, 1, horizontal sync to pin.
- o_VSync, out, 1, vertical sync to pin.
- o_Active, out, 1, output pixel is inside the visible area.
- o_Line_Start, out, 1, one-clock strobe on the output pixel at column 0.
- o_Frame_Start, out, 1, one-clock strobe on the output pixel at column 0, row 0.
- o_Red_Video, out, VIDEO_WIDTH, blanked red to DAC.
- o_Grn_Video, out, VIDEO_WIDTH, blanked green to DAC.
- o_Blu_Video, out, VIDEO_WIDTH, blanked blue to DAC.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high, sampled on rising i_Clk.
- Derived totals:
  - TOTAL_COLS = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK.
  - TOTAL_ROWS = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK.
  - Every porch and sync parameter must be at least 1.
- Counters:
  - Column counts 0..TOTAL_COLS-1 and wraps to 0.
  - Row increments only on a column wrap, counts 0..TOTAL_ROWS-1, and wraps to 0.
  - Both counters run free and never stall.
- Horizontal regions, by column:
  - Active: 0..ACTIVE_COLS-1.
  - Front porch: next H_FRONT columns.
  - Sync: next H_SYNC columns.
  - Back porch: last H_BACK columns.
- Vertical regions: same ordering, by row, using V_FRONT, V_SYNC and V_BACK.
- Sync and flag generation:
  - Raw HSync is at SYNC_POL in the horizontal sync region, ~SYNC_POL elsewhere.
  - Raw VSync follows the same rule for the vertical sync region, across whole lines.
  - Raw active = column active AND row active.
- Alignment:
  - Raw sync, active and strobe flags pass through a VIDEO_DELAY-stage shift pipeline, then one output register.
  - i_*_Video is sampled when that pipeline is at stage VIDEO_DELAY, then registered.
  - Every output (except o_Col/o_Row) for counter value (c, r) at clock t appears at clock t+VIDEO_DELAY+1.
- Blanking: o_*_Video equals the sampled input when the delayed active flag is 1, otherwise 0.
- Reset, at the first edge with i_Reset=1:
  - Counters, all pipeline stages and the active flag clear to 0.
  - o_HSync and o_VSync go to ~SYNC_POL.
  - o_*_Video = 0; o_Line_Start = o_Frame_Start = 0.
- Held reset: values are held while i_Reset stays high. Reset mid-frame abandons the frame; no partial sync pulse is extended.
- After release: counters start at (0,0) on the first clock with i_Reset=0. Outputs stay inactive until the pipeline fills. The first o_Frame_Start arrives VIDEO_DELAY+1 clocks after release.
- VIDEO_DELAY=0: the source is combinational from o_Col/o_Row. Total output latency is then 1 clock.
- Frame boundaries: exactly one o_Frame_Start per TOTAL_COLS*TOTAL_ROWS clocks, and exactly one o_Line_Start per TOTAL_COLS clocks.

Test Plan:
Small configuration for all tests unless noted: ACTIVE_COLS=4, H_FRONT=1, H_SYNC=2, H_BACK=1 (TOTAL_COLS=8); ACTIVE_ROWS=3, V_FRONT=1, V_SYNC=1, V_BACK=1 (TOTAL_ROWS=6); VIDEO_DELAY=2; SYNC_POL=0. One frame is 48 clocks.
1. Hold reset 5 clocks, then release.
   - During reset: o_HSync=o_VSync=1 and video=0.
   - First o_Frame_Start 3 clocks after release, then every 48 clocks.
   - o_Line_Start every 8 clocks.
2. Free-run HSync.
   - o_HSync low for exactly 2 clocks per line, starting 5 clocks after each o_Line_Start.
   - o_VSync low for exactly 8 clocks, starting 32 clocks after o_Frame_Start.
3. Blanking: drive i_Red_Video=7 constantly.
   - o_Red_Video=7 only while o_Active=1.
   - Exactly 12 clocks per frame, in rows 0-2 at line offsets 0-3; 0 otherwise.
4. Alignment: a source model returns i_Red_Video = o_Col delayed 2 clocks, i_Grn_Video = o_Row delayed 2 clocks.
   - Output pixels per active line read Red 0,1,2,3 starting at o_Line_Start.
   - Green equals the row index 0,1,2.
5. Mid-frame reset: pulse i_Reset for 1 clock while o_Row=2, o_Col=3.
   - Next clock: o_Col=o_Row=0, syncs=1, video=0, o_Active=0.
   - o_Frame_Start 3 clocks after release.
6. Polarity and latency: rerun test 2 with SYNC_POL=1 and VIDEO_DELAY=0.
   - Sync pulses are high, with the same width and position.
   - Frame strobe lags (0,0) on o_Col/o_Row by 1 clock.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running col/row counters, publishes o_Col/o_Row, re-aligns source colour after VIDEO_DELAY, drives HSync/VSync/active/strobes/blanked RGB
module vga_timing_gen #(
    parameter int   VIDEO_WIDTH = 3,
    parameter int   ACTIVE_COLS = 640,
    parameter int   H_FRONT     = 18,
    parameter int   H_SYNC      = 92,
    parameter int   H_BACK      = 50,
    parameter int   ACTIVE_ROWS = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   VIDEO_DELAY = 2,
    parameter int   COUNT_WIDTH = 10
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic [COUNT_WIDTH-1:0] o_Col,
    output logic [COUNT_WIDTH-1:0] o_Row,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic                   o_Active,
    output logic                   o_Line_Start,
    output logic                   o_Frame_Start,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);
    localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
    localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
    localparam logic [COUNT_WIDTH-1:0] COL_ACT  = COUNT_WIDTH'(ACTIVE_COLS);
    localparam logic [COUNT_WIDTH-1:0] COL_SS   = COUNT_WIDTH'(ACTIVE_COLS + H_FRONT);
    localparam logic [COUNT_WIDTH-1:0] COL_SE   = COUNT_WIDTH'(ACTIVE_COLS + H_FRONT + H_SYNC);
    localparam logic [COUNT_WIDTH-1:0] COL_LAST = COUNT_WIDTH'(TOTAL_COLS - 1);
    localparam logic [COUNT_WIDTH-1:0] ROW_ACT  = COUNT_WIDTH'(ACTIVE_ROWS);
    localparam logic [COUNT_WIDTH-1:0] ROW_SS   = COUNT_WIDTH'(ACTIVE_ROWS + V_FRONT);
    localparam logic [COUNT_WIDTH-1:0] ROW_SE   = COUNT_WIDTH'(ACTIVE_ROWS + V_FRONT + V_SYNC);
    localparam logic [COUNT_WIDTH-1:0] ROW_LAST = COUNT_WIDTH'(TOTAL_ROWS - 1);

    logic [COUNT_WIDTH-1:0] col, row;
    logic [4:0] raw, tap;

    assign o_Col = col;
    assign o_Row = row;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= col == COL_LAST ? '0 : col + 1'b1;
            if (col == COL_LAST)
                row <= row == ROW_LAST ? '0 : row + 1'b1;
        end
    end

    // flag bits: [4] in hsync region, [3] in vsync region, [2] active, [1] line start, [0] frame start
    assign raw = {col >= COL_SS && col < COL_SE,
                  row >= ROW_SS && row < ROW_SE,
                  col < COL_ACT && row < ROW_ACT,
                  col == '0,
                  col == '0 && row == '0};

    generate
        if (VIDEO_DELAY == 0) begin : g_nodly
            assign tap = raw;
        end else begin : g_dly
            logic [4:0] dly [VIDEO_DELAY];
            always_ff @(posedge i_Clk) begin
                dly[0] <= i_Reset ? 5'd0 : raw;
                for (int k = 1; k < VIDEO_DELAY; k++)
                    dly[k] <= i_Reset ? 5'd0 : dly[k-1];
            end
            assign tap = dly[VIDEO_DELAY-1];
        end
    endgenerate

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_HSync       <= ~SYNC_POL;
            o_VSync       <= ~SYNC_POL;
            o_Active      <= 1'b0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Red_Video   <= '0;
            o_Grn_Video   <= '0;
            o_Blu_Video   <= '0;
        end else begin
            o_HSync       <= tap[4] ? SYNC_POL : ~SYNC_POL;
            o_VSync       <= tap[3] ? SYNC_POL : ~SYNC_POL;
            o_Active      <= tap[2];
            o_Line_Start  <= tap[1];
            o_Frame_Start <= tap[0];
            o_Red_Video   <= tap[2] ? i_Red_Video : '0;
            o_Grn_Video   <= tap[2] ? i_Grn_Video : '0;
            o_Blu_Video   <= tap[2] ? i_Blu_Video : '0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for two small-geometry vga_timing_gen instances (delay 2 active-low, delay 0 active-high)
module tb_vga_timing_gen;
    localparam int AC = 4, HF = 1, HS = 2, HB = 1;
    localparam int AR = 3, VF = 1, VS = 1, VB = 1;
    localparam int TC = AC + HF + HS + HB;
    localparam int TR = AR + VF + VS + VB;
    localparam int FR = TC * TR;
    localparam int VDA = 2;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       act;
        logic       ls;
        logic       fs;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] blu, a_ri, a_gi, b_ri, b_gi;
    logic [9:0] a_col, a_row, b_col, b_row;
    logic       a_hs, a_vs, a_act, a_ls, a_fs, b_hs, b_vs, b_act, b_ls, b_fs;
    logic [2:0] a_r, a_g, a_b, b_r, b_g, b_b;
    rec_t       a_rec, b_rec;

    assign a_rec = {a_col, a_row, a_hs, a_vs, a_act, a_ls, a_fs, a_r, a_g, a_b};
    assign b_rec = {b_col, b_row, b_hs, b_vs, b_act, b_ls, b_fs, b_r, b_g, b_b};

    vga_timing_gen #(
        .VIDEO_WIDTH(3), .ACTIVE_COLS(AC), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .ACTIVE_ROWS(AR), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .VIDEO_DELAY(VDA), .COUNT_WIDTH(10)
    ) dut_a (
        .i_Clk(clk), .i_Reset(rst),
        .i_Red_Video(a_ri), .i_Grn_Video(a_gi), .i_Blu_Video(blu),
        .o_Col(a_col), .o_Row(a_row), .o_HSync(a_hs), .o_VSync(a_vs),
        .o_Active(a_act), .o_Line_Start(a_ls), .o_Frame_Start(a_fs),
        .o_Red_Video(a_r), .o_Grn_Video(a_g), .o_Blu_Video(a_b)
    );

    vga_timing_gen #(
        .VIDEO_WIDTH(3), .ACTIVE_COLS(AC), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .ACTIVE_ROWS(AR), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b1), .VIDEO_DELAY(0), .COUNT_WIDTH(10)
    ) dut_b (
        .i_Clk(clk), .i_Reset(rst),
        .i_Red_Video(b_ri), .i_Grn_Video(b_gi), .i_Blu_Video(blu),
        .o_Col(b_col), .o_Row(b_row), .o_HSync(b_hs), .o_VSync(b_vs),
        .o_Active(b_act), .o_Line_Start(b_ls), .o_Frame_Start(b_fs),
        .o_Red_Video(b_r), .o_Grn_Video(b_g), .o_Blu_Video(b_b)
    );

    rec_t qa[$], qb[$];
    int compared = 0, mismatched = 0;

    function automatic rec_t idle(logic pol);
        rec_t e;
        e = '0;
        e.hs = ~pol;
        e.vs = ~pol;
        return e;
    endfunction

    // Expected outputs after the edge that consumes pixel p (p-th edge since release).
    function automatic rec_t model(int p, int vd, logic pol, logic [2:0] b);
        rec_t e;
        int q, c, r;
        e = idle(pol);
        e.col = 10'(((p + 1) % TC));
        e.row = 10'((((p + 1) / TC) % TR));
        q = p - vd;
        if (q >= 0) begin
            c = q % TC;
            r = (q / TC) % TR;
            e.hs  = (c >= AC + HF && c < AC + HF + HS) ? pol : ~pol;
            e.vs  = (r >= AR + VF && r < AR + VF + VS) ? pol : ~pol;
            e.act = c < AC && r < AR;
            e.ls  = c == 0;
            e.fs  = c == 0 && r == 0;
            if (e.act) begin
                e.r = 3'(c);
                e.g = 3'(r);
                e.b = b;
            end
        end
        return e;
    endfunction

    task automatic check(string n, rec_t e, rec_t a);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s t=%0t: got col=%0d row=%0d hs=%b vs=%b act=%b ls=%b fs=%b rgb=%0d/%0d/%0d, need col=%0d row=%0d hs=%b vs=%b act=%b ls=%b fs=%b rgb=%0d/%0d/%0d",
                     n, $time, a.col, a.row, a.hs, a.vs, a.act, a.ls, a.fs, a.r, a.g, a.b,
                     e.col, e.row, e.hs, e.vs, e.act, e.ls, e.fs, e.r, e.g, e.b);
        end
    endtask

    // Monitor: pops one expected record per DUT per clock and checks frame-level periodicity.
    initial begin
        int cyc = 0;
        int lf[2] = '{-1, -1};
        int ac[2] = '{0, 0};
        logic fs_v[2], act_v[2];
        rec_t x;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (qa.size() != 0) begin
                x = qa.pop_front();
                check("dut_a", x, a_rec);
            end
            if (qb.size() != 0) begin
                x = qb.pop_front();
                check("dut_b", x, b_rec);
            end
            fs_v[0] = a_fs; fs_v[1] = b_fs;
            act_v[0] = a_act; act_v[1] = b_act;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    lf[i] = -1;
                    ac[i] = 0;
                end else begin
                    if (fs_v[i] === 1'b1) begin
                        if (lf[i] >= 0) begin
                            compared++;
                            if (cyc - lf[i] != FR || ac[i] != AC * AR) begin
                                mismatched++;
                                $display("FAIL frame_period dut%0d: got period=%0d actives=%0d, need period=%0d actives=%0d",
                                         i, cyc - lf[i], ac[i], FR, AC * AR);
                            end
                        end
                        lf[i] = cyc;
                        ac[i] = 0;
                    end
                    if (act_v[i] === 1'b1) ac[i]++;
                end
            end
        end
    end

    // Driver: models the pixel sources, issues resets, pushes expectations.
    initial begin
        int pix = 0;
        logic do_rst, mid_done;
        logic [2:0] h1, h2, g1, g2;
        mid_done = 1'b0;
        h1 = '0; h2 = '0; g1 = '0; g2 = '0;
        rst = 1'b1; blu = '0;
        a_ri = '0; a_gi = '0; b_ri = '0; b_gi = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            do_rst = cyc < 5;
            if (!mid_done && pix >= FR && pix % FR == 2 * TC + 3) begin
                do_rst = 1'b1;
                mid_done = 1'b1;
            end
            if (cyc > 200 && $urandom_range(0, 299) == 0) do_rst = 1'b1;
            rst = do_rst;
            blu = 3'($urandom);
            a_ri = h2; h2 = h1; h1 = a_col[2:0];
            a_gi = g2; g2 = g1; g1 = a_row[2:0];
            b_ri = b_col[2:0];
            b_gi = b_row[2:0];
            if (do_rst) begin
                qa.push_back(idle(1'b0));
                qb.push_back(idle(1'b1));
                pix = 0;
            end else begin
                qa.push_back(model(pix, VDA, 1'b0, blu));
                qb.push_back(model(pix, 0, 1'b1, blu));
                pix++;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
